// File: rtl/serial_op_engine_if.sv
// Handshake bundle for serial_op_engine: job control, W-bit input/output beat streams, status.
// The engine side uses the slave modport; the job source / consumer side uses master.
interface serial_op_engine_if #(
    parameter int W  = 4,
    parameter int IW = 4
);
    logic          start;
    logic [2:0]    op;
    logic [IW-1:0] iters;
    logic          clear_acc;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic          busy;
    logic [1:0]    state_o;

    modport master (
        output start, op, iters, clear_acc, in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy, state_o
    );

    modport slave (
        input  start, op, iters, clear_acc, in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_last, busy, state_o
    );
endinterface

// File: rtl/serial_op_engine.sv
// Beat-serial operand loader, iterated accumulate engine and beat-serial result drain.
// Define SERIAL_OP_ENGINE_CHECKSUM_EN to append an XOR checksum beat to each result.
module serial_op_engine #(
    parameter int N  = 64,
    parameter int W  = 4,
    parameter int IW = 4
) (
    input logic               clk,
    input logic               rst,
    serial_op_engine_if.slave bus
);
    localparam int BEATS = N / W;
    localparam int BW    = $clog2(BEATS + 1);
`ifdef SERIAL_OP_ENGINE_CHECKSUM_EN
    localparam int LAST_BEAT = BEATS;
`else
    localparam int LAST_BEAT = BEATS - 1;
`endif
    localparam logic [BW-1:0] BEAT_ONE  = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [BW-1:0] LOAD_LAST = BW'(BEATS - 1);
    localparam logic [BW-1:0] OUT_LAST  = BW'(LAST_BEAT);
    localparam logic [IW-1:0] ITER_ONE  = {{(IW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        EXEC  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [N-1:0]  a_r, a_nxt_s;
    logic [N-1:0]  b_r, b_nxt_s;
    logic [N-1:0]  acc_r, acc_nxt_s;
    logic [BW-1:0] beat_r, beat_nxt_s;
    logic [IW-1:0] iter_r, iter_nxt_s;
    logic [IW-1:0] iters_r, iters_nxt_s;
    logic [2:0]    op_r, op_nxt_s;
    logic          in_ready_r, in_ready_nxt_s;
    logic          out_valid_r, out_valid_nxt_s;
    logic [W-1:0]  out_data_r, out_data_nxt_s;
    logic          out_last_r, out_last_nxt_s;
    logic          busy_r, busy_nxt_s;

    function automatic logic [N-1:0] alu(input logic [2:0] op, input logic [N-1:0] a,
                                         input logic [N-1:0] b, input logic [N-1:0] acc);
        logic [N:0]   sum;
        logic [N-1:0] mn, mx, df, sat, r;
        logic         a_ge_b;
        a_ge_b = (a >= b);
        mn     = a_ge_b ? b : a;
        mx     = a_ge_b ? a : b;
        df     = a_ge_b ? (a - b) : (b - a);
        sum    = {1'b0, a} + {1'b0, b};
        // Saturate when the add carries out of the top bit.
        sat    = sum[N] ? {N{1'b1}} : sum[N-1:0];
        case (op)
            3'd0:    r = (a & b) | acc;
            3'd1:    r = (a ^ b) + acc;
            3'd2:    r = df ^ acc;
            3'd3:    r = {acc[N-1:N/2], mn[N/2-1:0]};
            3'd4:    r = mx + (acc << 1'b1);
            3'd5:    r = sat & acc;
            3'd6:    r = ((a & b) + ((a ^ b) >> 1'b1)) | acc;
            3'd7:    r = {a[N-2:0], a[N-1]} ^ b ^ acc;
            default: r = acc;
        endcase
        return r;
    endfunction

    function automatic logic [W-1:0] beat_of(input logic [N-1:0] v, input logic [BW-1:0] idx);
        logic [W-1:0] r;
        r = {W{1'b0}};
        for (int k = 0; k < BEATS; k++) begin
            r = (idx == BW'(k)) ? v[k*W +: W] : r;
        end
        return r;
    endfunction

`ifdef SERIAL_OP_ENGINE_CHECKSUM_EN
    function automatic logic [W-1:0] xor_fold(input logic [N-1:0] v);
        logic [W-1:0] r;
        r = {W{1'b0}};
        for (int k = 0; k < BEATS; k++) begin
            r = r ^ v[k*W +: W];
        end
        return r;
    endfunction
`endif

    function automatic logic [W-1:0] drain_beat(input logic [N-1:0] v, input logic [BW-1:0] idx);
`ifdef SERIAL_OP_ENGINE_CHECKSUM_EN
        return (idx == BW'(BEATS)) ? xor_fold(v) : beat_of(v, idx);
`else
        return beat_of(v, idx);
`endif
    endfunction

    // Next-state, datapath updates and next values of the registered outputs.
    always_comb begin
        state_nxt_s = state_r;
        a_nxt_s     = a_r;
        b_nxt_s     = b_r;
        acc_nxt_s   = acc_r;
        beat_nxt_s  = beat_r;
        iter_nxt_s  = iter_r;
        iters_nxt_s = iters_r;
        op_nxt_s    = op_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    op_nxt_s    = bus.op;
                    iters_nxt_s = (bus.iters == {IW{1'b0}}) ? ITER_ONE : bus.iters;
                    acc_nxt_s   = bus.clear_acc ? {N{1'b0}} : acc_r;
                    beat_nxt_s  = {BW{1'b0}};
                    iter_nxt_s  = {IW{1'b0}};
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                if (bus.in_valid && in_ready_r) begin
                    for (int k = 0; k < BEATS; k++) begin
                        a_nxt_s[k*W +: W] = (beat_r == BW'(k)) ? bus.in_a : a_r[k*W +: W];
                        b_nxt_s[k*W +: W] = (beat_r == BW'(k)) ? bus.in_b : b_r[k*W +: W];
                    end
                    if (beat_r == LOAD_LAST) begin
                        beat_nxt_s  = {BW{1'b0}};
                        iter_nxt_s  = {IW{1'b0}};
                        state_nxt_s = EXEC;
                    end else begin
                        beat_nxt_s  = beat_r + BEAT_ONE;
                    end
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            EXEC: begin
                acc_nxt_s = alu(op_r, a_r, b_r, acc_r);
                if (iter_r == (iters_r - ITER_ONE)) begin
                    iter_nxt_s  = {IW{1'b0}};
                    state_nxt_s = DRAIN;
                end else begin
                    iter_nxt_s  = iter_r + ITER_ONE;
                end
            end
            DRAIN: begin
                if (out_valid_r && bus.out_ready) begin
                    if (beat_r == OUT_LAST) begin
                        beat_nxt_s  = {BW{1'b0}};
                        state_nxt_s = IDLE;
                    end else begin
                        beat_nxt_s  = beat_r + BEAT_ONE;
                    end
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        // Outputs are precomputed from next state so they leave flops with no path from out_ready.
        in_ready_nxt_s  = (state_nxt_s == LOAD);
        out_valid_nxt_s = (state_nxt_s == DRAIN);
        busy_nxt_s      = (state_nxt_s != IDLE);
        out_data_nxt_s  = (state_nxt_s == DRAIN) ? drain_beat(acc_nxt_s, beat_nxt_s) : {W{1'b0}};
        out_last_nxt_s  = (state_nxt_s == DRAIN) && (beat_nxt_s == OUT_LAST);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            a_r         <= {N{1'b0}};
            b_r         <= {N{1'b0}};
            acc_r       <= {N{1'b0}};
            beat_r      <= {BW{1'b0}};
            iter_r      <= {IW{1'b0}};
            iters_r     <= {IW{1'b0}};
            op_r        <= 3'd0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {W{1'b0}};
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            a_r         <= a_nxt_s;
            b_r         <= b_nxt_s;
            acc_r       <= acc_nxt_s;
            beat_r      <= beat_nxt_s;
            iter_r      <= iter_nxt_s;
            iters_r     <= iters_nxt_s;
            op_r        <= op_nxt_s;
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_data_r  <= out_data_nxt_s;
            out_last_r  <= out_last_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_last  = out_last_r;
    assign bus.busy      = busy_r;
    assign bus.state_o   = state_r;
endmodule

// File: tb/tb_serial_op_engine.sv
// Table-driven bench for serial_op_engine (N=16, W=4, IW=4) with a beat scoreboard queue.
// Honours SERIAL_OP_ENGINE_CHECKSUM_EN by expecting the extra XOR checksum beat.
module tb_serial_op_engine;
    localparam int N     = 16;
    localparam int W     = 4;
    localparam int IW    = 4;
    localparam int BEATS = N / W;
    localparam int NV    = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_op_engine_if #(.W(W), .IW(IW)) bus();
    serial_op_engine #(.N(N), .W(W), .IW(IW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [2:0]    op;
        logic [IW-1:0] iters;
        logic          clr;
        logic [N-1:0]  a;
        logic [N-1:0]  b;
        logic [N-1:0]  res;
        int            bp;
    } vec_t;

    vec_t         vecs [NV];
    vec_t         abort_vec;
    logic [W-1:0] sb_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " state_o idle"}, 32'(bus.state_o), 32'd0);
        check({tag, " busy idle"}, 32'(bus.busy), 32'd0);
        check({tag, " in_ready idle"}, 32'(bus.in_ready), 32'd0);
        check({tag, " out_valid idle"}, 32'(bus.out_valid), 32'd0);
        check({tag, " out_data idle"}, 32'(bus.out_data), 32'd0);
        check({tag, " out_last idle"}, 32'(bus.out_last), 32'd0);
    endtask

    task automatic run_job(input vec_t v, input string tag);
        int           lat;
        int           guard;
        int           eff;
        logic [W-1:0] ck;
        logic [W-1:0] exp_b;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.op        = v.op;
        bus.iters     = v.iters;
        bus.clear_acc = v.clr;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, " state LOAD"}, 32'(bus.state_o), 32'd1);
        check({tag, " busy LOAD"}, 32'(bus.busy), 32'd1);
        ck = 4'h0;
        for (int k = 0; k < BEATS; k++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = v.a[k*W +: W];
            bus.in_b     = v.b[k*W +: W];
            sb_q.push_back(v.res[k*W +: W]);
            ck = ck ^ v.res[k*W +: W];
            guard = 0;
            while (!bus.in_ready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            check({tag, " in_ready wait"}, 32'(bus.in_ready), 32'd1);
            @(negedge clk);
        end
`ifdef SERIAL_OP_ENGINE_CHECKSUM_EN
        sb_q.push_back(ck);
`endif
        bus.in_valid = 1'b0;
        eff = (v.iters == 4'd0) ? 1 : int'(v.iters);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " out_valid latency"}, 32'(lat), 32'(eff + 1));
        for (int i = 0; i < v.bp; i++) begin
            check({tag, " bp valid hold"}, 32'(bus.out_valid), 32'd1);
            check({tag, " bp data hold"}, 32'(bus.out_data), 32'(sb_q[0]));
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        guard = 0;
        while (sb_q.size() > 0 && guard < 40) begin
            if (bus.out_valid) begin
                exp_b = sb_q.pop_front();
                check({tag, " out_data"}, 32'(bus.out_data), 32'(exp_b));
                check({tag, " out_last"}, 32'(bus.out_last), 32'(sb_q.size() == 0));
            end
            @(negedge clk);
            guard++;
        end
        check({tag, " drain leftover"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        bus.out_ready = 1'b0;
        check_idle({tag, " end"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start     = 1'b0;
        bus.op        = 3'd0;
        bus.iters     = 4'd0;
        bus.clear_acc = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = 4'h0;
        bus.in_b      = 4'h0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;

        // Order matters: jobs without clear build on the previous accumulator.
        vecs[0]  = '{op:3'd0, iters:4'd1,  clr:1'b1, a:16'h00F0, b:16'h0FF0, res:16'h00F0, bp:0};
        vecs[1]  = '{op:3'd1, iters:4'd3,  clr:1'b1, a:16'h0003, b:16'h0001, res:16'h0006, bp:0};
        vecs[2]  = '{op:3'd1, iters:4'd1,  clr:1'b0, a:16'h0003, b:16'h0001, res:16'h0008, bp:0};
        vecs[3]  = '{op:3'd0, iters:4'd1,  clr:1'b1, a:16'h00FF, b:16'h00FF, res:16'h00FF, bp:0};
        vecs[4]  = '{op:3'd5, iters:4'd1,  clr:1'b0, a:16'hFFFF, b:16'h0001, res:16'h00FF, bp:0};
        vecs[5]  = '{op:3'd2, iters:4'd1,  clr:1'b0, a:16'h0010, b:16'h0030, res:16'h00DF, bp:0};
        vecs[6]  = '{op:3'd3, iters:4'd1,  clr:1'b0, a:16'h1234, b:16'h5678, res:16'h0034, bp:0};
        vecs[7]  = '{op:3'd4, iters:4'd2,  clr:1'b0, a:16'h0005, b:16'h0009, res:16'h00EB, bp:3};
        vecs[8]  = '{op:3'd6, iters:4'd1,  clr:1'b1, a:16'h000C, b:16'h000A, res:16'h000B, bp:0};
        vecs[9]  = '{op:3'd7, iters:4'd0,  clr:1'b0, a:16'h8001, b:16'h00F0, res:16'h00F8, bp:0};
        vecs[10] = '{op:3'd5, iters:4'd1,  clr:1'b0, a:16'h1000, b:16'h0234, res:16'h0030, bp:0};
        vecs[11] = '{op:3'd1, iters:4'd15, clr:1'b0, a:16'h0001, b:16'h0000, res:16'h003F, bp:0};
        vecs[12] = '{op:3'd4, iters:4'd1,  clr:1'b1, a:16'hFFFF, b:16'h0000, res:16'hFFFF, bp:0};
        vecs[13] = '{op:3'd1, iters:4'd1,  clr:1'b0, a:16'h0001, b:16'h0000, res:16'h0000, bp:0};
        vecs[14] = '{op:3'd0, iters:4'd1,  clr:1'b1, a:16'h1234, b:16'hFFFF, res:16'h1234, bp:2};
        abort_vec = '{op:3'd7, iters:4'd1, clr:1'b1, a:16'h8001, b:16'h0000, res:16'h0003, bp:0};

        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        // Beats offered while idle must be ignored.
        bus.in_valid = 1'b1;
        bus.in_a     = 4'hA;
        bus.in_b     = 4'h5;
        @(negedge clk);
        check("idle in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_job(vecs[i], $sformatf("v%0d", i));
        end

        // Abort a job after two load beats.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.op        = 3'd0;
        bus.iters     = 4'd1;
        bus.clear_acc = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 4'hF;
            bus.in_b     = 4'hF;
            @(negedge clk);
        end
        check("abort mid LOAD", 32'(bus.state_o), 32'd1);
        rst = 1'b1;
        #1;
        check_idle("abort");
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post-abort out_valid", 32'(bus.out_valid), 32'd0);
            check("post-abort state", 32'(bus.state_o), 32'd0);
        end
        run_job(abort_vec, "after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_op_engine.md
# serial_op_engine

Parametrised, handshaked successor to the nibble-serial FSM datapath. It loads two N-bit operands in W-bit beats over a valid/ready input stream. It then applies one of eight accumulate operations for a programmable number of iterations, and streams the N-bit accumulator back out in W-bit beats with backpressure. It sits between the pad-level shim (narrow pins) and any wide-datapath consumer.

## Interface
- N, 64, operand/accumulator width; N % W == 0, N/W ≥ 2, N even
- W, 4, beat width
- IW, 4, width of iteration-count input
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- start  in  1  job request; honoured only in IDLE
- op  in  3  operation select, sampled on accepted start
- iters  in  IW  EXEC cycles, sampled on accepted start; 0 treated as 1
- clear_acc  in  1  sampled on accepted start; 1 = zero accumulator
- in_valid  in  1  input beat valid
- in_ready  out  1  high only in LOAD
- in_a, in_b  in  W each  operand beats
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accept
- out_data  out  W  output beat; 0 when out_valid=0
- out_last  out  1  high with final output beat
- busy  out  1  state != IDLE
- state_o  out  2  IDLE=0, LOAD=1, EXEC=2, DRAIN=3

## Operation
- BEATS = N/W. Beat k carries bits [k*W +: W], LSB beat first, both directions.
- Registers:
  - a, b: operands.
  - acc: N-bit accumulator; it persists across jobs unless cleared.
  - beat counter.
  - iteration counter.
- IDLE:
  - On start, latch op and iters (0→1). If clear_acc, acc←0. Beat counter←0. Go to LOAD.
- LOAD:
  - On each in_valid & in_ready: a[k]←in_a, b[k]←in_b, k++.
  - On beat BEATS-1: go to EXEC.
- EXEC: each cycle acc←f(a,b,acc), all mod 2^N. The op set is:
  - 0: (a&b)|acc
  - 1: (a^b)+acc
  - 2: |a−b| ^ acc
  - 3: {acc[N-1:N/2], min(a,b)[N/2-1:0]}
  - 4: max(a,b)+(acc<<1)
  - 5: sat(a+b) & acc, where sat clamps to all-ones on carry out of bit N-1
  - 6: ((a&b)+((a^b)>>1)) | acc
  - 7: {a[N-2:0],a[N-1]} ^ b ^ acc
  - After `iters` updates, go to DRAIN.
- DRAIN:
  - out_valid=1, out_data=acc beat k.
  - On out_valid & out_ready: k++.
  - After the final beat is accepted: go to IDLE, beat counter←0.
- start outside IDLE is ignored. Input beats presented outside LOAD are not accepted.
- Reset mid-operation aborts the job: no further beats are emitted and all registers return to reset values.

## Timing
- Reset values:
  - state IDLE
  - acc, a, b, counters = 0
  - in_ready, out_valid, out_data, out_last, busy = 0
  - state_o = 0
- start sampled at edge t → LOAD from cycle t+1. in_ready is a registered state decode and has no combinational path from in_valid.
- Last input beat accepted at edge t → EXEC for cycles t+1 … t+iters. The first out_valid is in cycle t+iters+1.
- Output beats hold stable while out_valid & !out_ready. A new beat is presented the cycle after each handshake. The minimum DRAIN time is BEATS cycles.
- Total job time with no stalls is 1 + BEATS + iters + BEATS cycles, start edge to IDLE.
- out_data and out_last are registered-state functions only; there is no combinational path from out_ready.

## Configuration
- SERIAL_OP_ENGINE_CHECKSUM_EN defined:
  - DRAIN emits one extra beat after the BEATS result beats. Its value is the XOR of all result beats.
  - out_last asserts on the checksum beat only. DRAIN lasts BEATS+1 beats.
- Undefined:
  - No checksum beat. out_last asserts on result beat BEATS-1.

## Test plan
Bench uses N=16, W=4, IW=4.
- Op 0:
  - Stimulus: op=0, clear_acc=1, iters=1, A=0x00F0, B=0x0FF0.
  - Response: beats 0,F,0,0; out_last on 4th; out_valid first appears 2 cycles after last input handshake.
- Op 1 chaining:
  - Stimulus: op=1, clear_acc=1, iters=3, A=0x0003, B=0x0001.
  - Response: acc 2,4,6 → output 0x0006.
  - Follow-up: job op=1, clear_acc=0, iters=1, same A/B → 0x0008.
- Op 5 saturation:
  - Stimulus: prior acc=0x00FF, op=5, clear_acc=0, A=0xFFFF, B=0x0001.
  - Response: sat=0xFFFF → output 0x00FF.
- Backpressure:
  - Stimulus: out_ready low for 3 cycles after the first out_valid.
  - Response: out_valid stays 1 and out_data holds beat 0; after release, all 4 beats arrive in order with none lost or duplicated.
- Reset abort:
  - Stimulus: rst pulse after 2 LOAD beats.
  - Response: all outputs 0 and state_o=0 within the reset cycle. The next full job (op=7, clear, A=0x8001, B=0, iters=1) gives 0x0003.
- Checksum (CHECKSUM_EN build):
  - Stimulus: job producing result 0x1234.
  - Response: beats 4,3,2,1 then checksum 0x4; out_last only on the 5th beat.
